// File: rtl/vga_pkg.sv
// Shared VGA frame-buffer constants and the write-arbiter state type.
package vga_pkg;

  localparam int H_ACTIVE  = 640;
  localparam int V_ACTIVE  = 480;
  localparam int FB_ADDR_W = $clog2(H_ACTIVE * V_ACTIVE);
  localparam int FB_DATA_W = 12;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

endpackage

// File: rtl/vblank_write_arbiter_rr_select.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_select #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             valid,
  output logic [N-1:0]     winner,
  output logic [IDX_W-1:0] winner_idx,
  output logic             found
);

  logic [N-1:0] rot;
  int           off;
  int           sum;

  // Rotate the request vector so the pointer lands on bit 0; the lowest set bit wins.
  always_comb begin
    rot        = N'({req, req} >> ptr);
    off        = 0;
    sum        = 0;
    winner     = '0;
    winner_idx = '0;
    found      = 1'b0;
    if (valid && |req) begin
      for (int k = N - 1; k >= 0; k--) begin
        if (rot[k]) off = k;
      end
      sum = int'(ptr) + off;
      if (sum >= N) sum = sum - N;
      winner     = {{(N-1){1'b0}}, 1'b1} << sum;
      winner_idx = IDX_W'(sum);
      found      = 1'b1;
    end
  end

endmodule

// File: rtl/vblank_write_arbiter.sv
// Round-robin burst arbiter that lets draw modules write the frame buffer only during vertical blanking.
module vblank_write_arbiter
  import vga_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int ADDR_W    = FB_ADDR_W,
  parameter int DATA_W    = FB_DATA_W,
  parameter int MAX_BURST = 64,
  parameter int FRAME_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      vblnk,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        wr_valid,
  input  logic [NUM_REQ-1:0]        wr_last,
  input  logic [NUM_REQ*ADDR_W-1:0] wr_addr,
  input  logic [NUM_REQ*DATA_W-1:0] wr_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        wr_ready,
  output logic [NUM_REQ-1:0]        abort,
  output logic                      fb_we,
  output logic [ADDR_W-1:0]         fb_addr,
  output logic [DATA_W-1:0]         fb_data,
  output logic [FRAME_W-1:0]        frame_cnt
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  arb_state_t         state, state_n;
  logic [NUM_REQ-1:0] gnt_n;
  logic [IDX_W-1:0]   gnt_idx, gnt_idx_n;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_n;
  logic [CNT_W-1:0]   beat_cnt, beat_cnt_n;
  logic               vblnk_d;
  logic               accept;
  logic               last_sel;
  logic               req_sel;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic [NUM_REQ-1:0] win;
  logic [IDX_W-1:0]   win_idx;
  logic               win_found;

  rr_select #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_select (
    .req        (req),
    .ptr        (rr_ptr),
    .valid      (vblnk),
    .winner     (win),
    .winner_idx (win_idx),
    .found      (win_found)
  );

  // The grant is one-hot, so masking by it selects the owner's beat without an index mux.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_addr = sel_addr | wr_addr[i*ADDR_W +: ADDR_W];
        sel_data = sel_data | wr_data[i*DATA_W +: DATA_W];
      end
    end
    last_sel = |(gnt & wr_last);
    req_sel  = |(gnt & req);
  end

  always_comb begin
    state_n    = state;
    gnt_n      = gnt;
    gnt_idx_n  = gnt_idx;
    rr_ptr_n   = rr_ptr;
    beat_cnt_n = beat_cnt;
    wr_ready   = '0;
    abort      = '0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_n    = BURST;
          gnt_n      = win;
          gnt_idx_n  = win_idx;
          beat_cnt_n = '0;
        end
      end
      BURST: begin
        wr_ready = vblnk ? gnt : '0;
        abort    = vblnk ? '0 : gnt;
        accept   = vblnk & |(gnt & wr_valid);
        if (accept) beat_cnt_n = beat_cnt + 1'b1;
        if (!vblnk || (accept && (last_sel || beat_cnt_n == MAX_CNT)) || !req_sel) begin
          state_n  = IDLE;
          gnt_n    = '0;
          rr_ptr_n = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_idx  <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      gnt_idx  <= gnt_idx_n;
      rr_ptr   <= rr_ptr_n;
      beat_cnt <= beat_cnt_n;
    end
  end

  // Address and data hold their last written value; only fb_we marks a fresh beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fb_we   <= 1'b0;
      fb_addr <= '0;
      fb_data <= '0;
    end else begin
      fb_we <= accept;
      if (accept) begin
        fb_addr <= sel_addr;
        fb_data <= sel_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vblnk_d   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      vblnk_d <= vblnk;
      if (vblnk && !vblnk_d) frame_cnt <= frame_cnt + 1'b1;
    end
  end

  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst) $onehot0(gnt));
  a_abort_owner : assert property (@(posedge clk) disable iff (!rst) (abort & ~gnt) == '0);
  a_we_in_blank : assert property (@(posedge clk) disable iff (!rst) fb_we |-> $past(vblnk));

endmodule

// File: tb/tb_vblank_write_arbiter.sv
// Directed and random stimulus against a cycle-level reference model of the blanking write arbiter.
module tb_vblank_write_arbiter;

  localparam int NUM_REQ   = 3;
  localparam int ADDR_W    = 19;
  localparam int DATA_W    = 12;
  localparam int MAX_BURST = 64;
  localparam int FRAME_W   = 8;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      vblnk = 1'b0;
  logic [NUM_REQ-1:0]        req = '0;
  logic [NUM_REQ-1:0]        wr_valid = '0;
  logic [NUM_REQ-1:0]        wr_last = '0;
  logic [NUM_REQ*ADDR_W-1:0] wr_addr = '0;
  logic [NUM_REQ*DATA_W-1:0] wr_data = '0;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        wr_ready;
  logic [NUM_REQ-1:0]        abort;
  logic                      fb_we;
  logic [ADDR_W-1:0]         fb_addr;
  logic [DATA_W-1:0]         fb_data;
  logic [FRAME_W-1:0]        frame_cnt;

  int errors = 0;
  int checks = 0;

  int                m_g;
  int                m_cnt;
  int                m_ptr;
  int                m_frame;
  bit                m_vd;
  bit                m_we;
  bit                m_acc;
  int                m_acc_idx;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;

  logic [NUM_REQ-1:0] seen_gnt;
  logic [NUM_REQ-1:0] seen_abort;
  logic               seen_we;
  logic [FRAME_W-1:0] seen_frame;

  vblank_write_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MAX_BURST (MAX_BURST),
    .FRAME_W   (FRAME_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .vblnk     (vblnk),
    .req       (req),
    .wr_valid  (wr_valid),
    .wr_last   (wr_last),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .gnt       (gnt),
    .wr_ready  (wr_ready),
    .abort     (abort),
    .fb_we     (fb_we),
    .fb_addr   (fb_addr),
    .fb_data   (fb_data),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [NUM_REQ-1:0] onehot(input int i);
    return (i < 0) ? '0 : NUM_REQ'(1 << i);
  endfunction

  function automatic int gntIndex(input logic [NUM_REQ-1:0] g);
    return (g == 3'b001) ? 0 : (g == 3'b010) ? 1 : (g == 3'b100) ? 2 : -1;
  endfunction

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_g     = -1;
    m_cnt   = 0;
    m_ptr   = 0;
    m_frame = 0;
    m_vd    = 1'b0;
    m_we    = 1'b0;
    m_acc   = 1'b0;
    m_addr  = '0;
    m_data  = '0;
  endtask

  // One clock of the arbiter rules, applied to the inputs currently driven.
  task automatic modelStep();
    bit found;
    int cand;
    found     = 1'b0;
    m_acc     = (m_g >= 0) && vblnk && wr_valid[m_g];
    m_acc_idx = m_g;
    m_we      = m_acc;
    if (m_acc) begin
      m_addr = wr_addr[m_g*ADDR_W +: ADDR_W];
      m_data = wr_data[m_g*DATA_W +: DATA_W];
    end
    if (vblnk && !m_vd) m_frame = (m_frame + 1) % (1 << FRAME_W);
    m_vd = vblnk;
    if (m_g < 0) begin
      if (vblnk) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          cand = (m_ptr + k) % NUM_REQ;
          if (!found && req[cand]) begin
            found = 1'b1;
            m_g   = cand;
            m_cnt = 0;
          end
        end
      end
    end else begin
      if (m_acc) m_cnt++;
      if (!vblnk || (m_acc && wr_last[m_g]) || (m_acc && m_cnt == MAX_BURST) || !req[m_g]) begin
        m_ptr = (m_g + 1) % NUM_REQ;
        m_g   = -1;
      end
    end
  endtask

  task automatic checkOutput();
    logic [NUM_REQ-1:0] g;
    g          = onehot(m_g);
    seen_gnt   = gnt;
    seen_abort = abort;
    seen_we    = fb_we;
    seen_frame = frame_cnt;
    checkVal("gnt", gnt, g);
    checkVal("wr_ready", wr_ready, (m_g >= 0 && vblnk) ? g : '0);
    checkVal("abort", abort, (m_g >= 0 && !vblnk) ? g : '0);
    checkVal("fb_we", fb_we, m_we);
    if (m_we) begin
      checkVal("fb_addr", fb_addr, m_addr);
      checkVal("fb_data", fb_data, m_data);
    end
    checkVal("frame_cnt", frame_cnt, m_frame);
  endtask

  // Drive one cycle of inputs with fresh random payloads, check, then advance to just after the edge.
  task automatic applyStimulus(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ-1:0] v,
                               input logic [NUM_REQ-1:0] l, input logic vb);
    req      = r;
    wr_valid = v;
    wr_last  = l;
    vblnk    = vb;
    for (int i = 0; i < NUM_REQ; i++) begin
      wr_addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
      wr_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
    end
    #1;
    checkOutput();
    if (rst) modelStep();
    else m_acc = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int                 grants[$];
    int                 sent[NUM_REQ];
    int                 nacc, wcount, aborts, guard;
    logic [NUM_REQ-1:0] prev_gnt, lastv, first_gnt, r, v, l;
    logic               vb;

    modelReset();
    #1 rst = 1'b0;
    repeat (3) applyStimulus('0, '0, '0, 1'b0);
    rst = 1'b1;
    $display("[TB] reset then idle with blanking off");
    repeat (20) applyStimulus(3'b111, '0, '0, 1'b0);

    $display("[TB] round-robin bursts of four");
    for (int i = 0; i < NUM_REQ; i++) sent[i] = 0;
    prev_gnt = '0;
    guard    = 0;
    while (grants.size() < 4 && guard < 80) begin
      for (int i = 0; i < NUM_REQ; i++) lastv[i] = (sent[i] % 4 == 3);
      applyStimulus(3'b111, 3'b111, lastv, 1'b1);
      if (m_acc) sent[m_acc_idx]++;
      if (seen_gnt != '0 && prev_gnt == '0) grants.push_back(gntIndex(seen_gnt));
      prev_gnt = seen_gnt;
      guard++;
    end
    checkVal("rr_grant_count", grants.size(), 4);
    for (int i = 0; i < 4; i++)
      checkVal("rr_order", (i < grants.size()) ? grants[i] : -1, i % NUM_REQ);

    $display("[TB] blanking ends mid-burst");
    repeat (3) applyStimulus('0, '0, '0, 1'b0);
    nacc = 0; wcount = 0; guard = 0;
    while (nacc < 10 && guard < 40) begin
      applyStimulus(3'b001, 3'b001, '0, 1'b1);
      nacc += int'(m_acc);
      wcount += int'(seen_we);
      guard++;
    end
    checkVal("blank_beats", nacc, 10);
    applyStimulus(3'b011, 3'b001, '0, 1'b0);
    wcount += int'(seen_we);
    checkVal("abort_pulse", seen_abort, 3'b001);
    checkVal("abort_gnt_held", seen_gnt, 3'b001);
    applyStimulus(3'b011, 3'b001, '0, 1'b0);
    wcount += int'(seen_we);
    checkVal("abort_gnt_cleared", seen_gnt, 3'b000);
    checkVal("abort_one_cycle", seen_abort, 3'b000);
    repeat (4) begin
      applyStimulus(3'b011, 3'b001, '0, 1'b0);
      wcount += int'(seen_we);
    end
    checkVal("blank_writes", wcount, 10);
    guard = 0;
    seen_gnt = '0;
    while (seen_gnt == '0 && guard < 10) begin
      applyStimulus(3'b011, '0, '0, 1'b1);
      guard++;
    end
    checkVal("resume_grant", seen_gnt, 3'b010);
    repeat (3) applyStimulus('0, '0, '0, 1'b1);

    $display("[TB] max burst forced yield");
    wcount = 0; aborts = 0; guard = 0; first_gnt = '0;
    while (seen_gnt != 3'b010 && guard < 200) begin
      applyStimulus(3'b011, 3'b011, '0, 1'b1);
      if (first_gnt == '0) first_gnt = seen_gnt;
      wcount += int'(seen_we);
      aborts += int'(|seen_abort);
      guard++;
    end
    checkVal("yield_first_owner", first_gnt, 3'b001);
    checkVal("yield_writes", wcount, MAX_BURST);
    checkVal("yield_next_owner", seen_gnt, 3'b010);
    checkVal("yield_aborts", aborts, 0);

    $display("[TB] frame counter wrap");
    rst = 1'b0;
    modelReset();
    repeat (2) applyStimulus('0, '0, '0, 1'b0);
    rst = 1'b1;
    repeat (1 << FRAME_W) begin
      applyStimulus('0, '0, '0, 1'b1);
      applyStimulus('0, '0, '0, 1'b0);
    end
    checkVal("frame_wrap", seen_frame, 0);
    repeat (50) applyStimulus('0, '0, '0, 1'b1);
    checkVal("frame_level_once", seen_frame, 1);

    $display("[TB] asynchronous reset mid-burst");
    nacc = 0; guard = 0;
    while (nacc < 4 && guard < 20) begin
      applyStimulus(3'b001, 3'b001, '0, 1'b1);
      nacc += int'(m_acc);
      guard++;
    end
    checkVal("pre_reset_beats", nacc, 4);
    checkVal("pre_reset_gnt", gnt, 3'b001);
    #2 rst = 1'b0;
    #1;
    checkVal("async_gnt", gnt, 3'b000);
    checkVal("async_fb_we", fb_we, 1'b0);
    checkVal("async_abort", abort, 3'b000);
    checkVal("async_frame", frame_cnt, 0);
    modelReset();
    repeat (2) applyStimulus(3'b001, 3'b001, '0, 1'b1);
    rst = 1'b1;
    wcount = 0;
    repeat (5) begin
      applyStimulus('0, '0, '0, 1'b1);
      wcount += int'(seen_we);
    end
    checkVal("no_stale_write", wcount, 0);

    $display("[TB] randomized traffic");
    vb = 1'b1;
    repeat (1500) begin
      if ($urandom_range(0, 19) == 0) vb = ~vb;
      r = NUM_REQ'($urandom) | NUM_REQ'($urandom);
      v = NUM_REQ'($urandom);
      l = ($urandom_range(0, 7) == 0) ? NUM_REQ'($urandom) : '0;
      applyStimulus(r, v, l, vb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
